// File: rtl/max7219_pkg.sv
// -----------------------------------------------------------------------------
// max7219_pkg
// Shared definitions for the MAX7219 cascaded-chain driver:
//   - MAX7219 register addresses
//   - the power-up configuration word table
//   - the word transmitter state encoding
//   - chain geometry constants
// -----------------------------------------------------------------------------
package max7219_pkg;

  // Chain geometry: four devices, one 16-bit {addr, data} word each
  localparam int N_DEV      = 4;
  localparam int WORD_BITS  = 64;
  localparam int INIT_WORDS = 5;

  // MAX7219 register map
  localparam logic [7:0] REG_DIGIT0       = 8'h01;
  localparam logic [7:0] REG_DIGIT1       = 8'h02;
  localparam logic [7:0] REG_DIGIT2       = 8'h03;
  localparam logic [7:0] REG_DIGIT3       = 8'h04;
  localparam logic [7:0] REG_DIGIT4       = 8'h05;
  localparam logic [7:0] REG_DIGIT5       = 8'h06;
  localparam logic [7:0] REG_DIGIT6       = 8'h07;
  localparam logic [7:0] REG_DIGIT7       = 8'h08;
  localparam logic [7:0] REG_DECODE       = 8'h09;
  localparam logic [7:0] REG_INTENSITY    = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN     = 8'h0C;
  localparam logic [7:0] REG_DISPLAY_TEST = 8'h0F;

  // Configuration words in broadcast order. Entry 3 carries only the
  // intensity address; its data nibble comes from the driver parameter.
  localparam logic [15:0] INIT_TABLE [INIT_WORDS] = '{
    {REG_DISPLAY_TEST, 8'h00},
    {REG_SCAN_LIMIT,   8'h07},
    {REG_DECODE,       8'h00},
    {REG_INTENSITY,    8'h00},
    {REG_SHUTDOWN,     8'h01}
  };

  // Word transmitter phases
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT_LO,
    TX_SHIFT_HI,
    TX_HOLD,
    TX_GAP
  } txState_e;

  // One 16-bit configuration word, intensity substituted in at index 3
  function automatic logic [15:0] initEntry(input logic [2:0] idx,
                                            input logic [3:0] intensity);
    logic [15:0] w_entry;
    w_entry = INIT_TABLE[4];
    case (idx)
      3'd0:    w_entry = INIT_TABLE[0];
      3'd1:    w_entry = INIT_TABLE[1];
      3'd2:    w_entry = INIT_TABLE[2];
      3'd3:    w_entry = {INIT_TABLE[3][15:8], 4'h0, intensity};
      default: w_entry = INIT_TABLE[4];
    endcase
    return w_entry;
  endfunction

endpackage

// File: rtl/max7219_word_tx.sv
// -----------------------------------------------------------------------------
// max7219_word_tx
// Shifts one 64-bit chain word out MSB first over DIN/CLK/LOAD.
// Phases: LOAD (1 cycle), 64 x {SHIFT_LO, SHIFT_HI} (CLK_DIV each),
// HOLD (CLK_DIV), GAP (2*CLK_DIV, CS high so the chain latches).
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start         request a word; accepted in IDLE or on the GAP exit cycle
//   i_word          word to send, sampled during the LOAD cycle
//   o_load          high during the LOAD cycle
//   o_done          one-cycle pulse on the last GAP cycle
//   o_din, o_sclk, o_cs_n  registered serial link outputs
// -----------------------------------------------------------------------------
module max7219_word_tx
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_word,
  output logic        o_load,
  output logic        o_done,
  output logic        o_din,
  output logic        o_sclk,
  output logic        o_cs_n
);

  localparam logic [8:0] DIV_M1 = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_M1 = 9'(2 * CLK_DIV - 1);

  txState_e    r_state;
  logic [8:0]  r_divCnt;
  logic [5:0]  r_bitCnt;
  logic [63:0] r_shift;
  logic        r_din;
  logic        r_sclk;
  logic        r_csN;

  txState_e    w_stateNext;
  logic [8:0]  w_divNext;
  logic [5:0]  w_bitNext;
  logic [63:0] w_shiftNext;
  logic        w_lastTick;
  logic        w_dinNext;
  logic        w_sclkNext;
  logic        w_csNNext;

  // Next-state logic. Each timed phase loads r_divCnt with its length minus
  // one on entry and leaves when it reaches zero. The pin values are derived
  // from the next state so that the registered pins line up with the phase.
  always_comb begin
    w_stateNext = r_state;
    w_divNext   = r_divCnt;
    w_bitNext   = r_bitCnt;
    w_shiftNext = r_shift;
    w_lastTick  = (r_divCnt == 9'd0);

    case (r_state)
      TX_IDLE: begin
        if (i_start) w_stateNext = TX_LOAD;
      end
      TX_LOAD: begin
        w_shiftNext = i_word;
        w_bitNext   = 6'd63;
        w_divNext   = DIV_M1;
        w_stateNext = TX_SHIFT_LO;
      end
      TX_SHIFT_LO: begin
        if (w_lastTick) begin
          w_divNext   = DIV_M1;
          w_stateNext = TX_SHIFT_HI;
        end else begin
          w_divNext = r_divCnt - 9'd1;
        end
      end
      TX_SHIFT_HI: begin
        if (w_lastTick) begin
          w_shiftNext = {r_shift[62:0], 1'b0};
          w_divNext   = DIV_M1;
          if (r_bitCnt == 6'd0) begin
            w_stateNext = TX_HOLD;
          end else begin
            w_bitNext   = r_bitCnt - 6'd1;
            w_stateNext = TX_SHIFT_LO;
          end
        end else begin
          w_divNext = r_divCnt - 9'd1;
        end
      end
      TX_HOLD: begin
        if (w_lastTick) begin
          w_divNext   = GAP_M1;
          w_stateNext = TX_GAP;
        end else begin
          w_divNext = r_divCnt - 9'd1;
        end
      end
      TX_GAP: begin
        if (w_lastTick) begin
          w_stateNext = i_start ? TX_LOAD : TX_IDLE;
        end else begin
          w_divNext = r_divCnt - 9'd1;
        end
      end
      default: w_stateNext = TX_IDLE;
    endcase

    w_csNNext  = !((w_stateNext == TX_SHIFT_LO) || (w_stateNext == TX_SHIFT_HI) ||
                   (w_stateNext == TX_HOLD));
    w_sclkNext = (w_stateNext == TX_SHIFT_HI);
    w_dinNext  = ((w_stateNext == TX_SHIFT_LO) || (w_stateNext == TX_SHIFT_HI)) ?
                 w_shiftNext[63] : 1'b0;
  end

  // State, counters, shifter and the registered link pins. Reset forces
  // CS high at once, which may latch a partial word in the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= TX_IDLE;
      r_divCnt <= 9'd0;
      r_bitCnt <= 6'd0;
      r_shift  <= 64'd0;
      r_din    <= 1'b0;
      r_sclk   <= 1'b0;
      r_csN    <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_divCnt <= w_divNext;
      r_bitCnt <= w_bitNext;
      r_shift  <= w_shiftNext;
      r_din    <= w_dinNext;
      r_sclk   <= w_sclkNext;
      r_csN    <= w_csNNext;
    end
  end

  assign o_load = (r_state == TX_LOAD);
  assign o_done = (r_state == TX_GAP) && w_lastTick;
  assign o_din  = r_din;
  assign o_sclk = r_sclk;
  assign o_cs_n = r_csN;

endmodule

// File: rtl/max7219_chain_driver.sv
// -----------------------------------------------------------------------------
// max7219_chain_driver
// Drives a 4-device cascaded MAX7219 chain: broadcasts the 5-word
// configuration sequence after reset or on request, then refreshes the
// eight row frames line1..line8 continuously.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_line1..i_line8    64-bit row frames, [63:48] is the farthest device
//   i_reinit            single-cycle request to rerun configuration
//   o_max_din           serial data, MSB first
//   o_max_clk           serial clock, idles low
//   o_max_cs_n          load/chip-select, rising edge latches the chain
//   o_init_done         high while refreshing rows
//   o_frame_done        one-cycle pulse after the line8 word is latched
// -----------------------------------------------------------------------------
module max7219_chain_driver
  import max7219_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8,
  parameter int         N_ROWS    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_line1,
  input  logic [63:0] i_line2,
  input  logic [63:0] i_line3,
  input  logic [63:0] i_line4,
  input  logic [63:0] i_line5,
  input  logic [63:0] i_line6,
  input  logic [63:0] i_line7,
  input  logic [63:0] i_line8,
  input  logic        i_reinit,
  output logic        o_max_din,
  output logic        o_max_clk,
  output logic        o_max_cs_n,
  output logic        o_init_done,
  output logic        o_frame_done
);

  localparam logic [2:0] LAST_ROW  = 3'(N_ROWS - 1);
  localparam logic [2:0] LAST_INIT = 3'(INIT_WORDS - 1);

  logic [2:0]  r_initIdx;
  logic [2:0]  r_rowIdx;
  logic        r_pending;
  logic        r_initDone;
  logic        r_frameDone;
  logic [63:0] r_frame [N_ROWS];

  logic [63:0] w_lines [N_ROWS];
  logic [63:0] w_word;
  logic [15:0] w_initEntry;
  logic        w_txLoad;
  logic        w_txDone;

  assign w_lines[0] = i_line1;
  assign w_lines[1] = i_line2;
  assign w_lines[2] = i_line3;
  assign w_lines[3] = i_line4;
  assign w_lines[4] = i_line5;
  assign w_lines[5] = i_line6;
  assign w_lines[6] = i_line7;
  assign w_lines[7] = i_line8;

  // Word presented to the transmitter. line1 is taken straight from the
  // input during its LOAD cycle because the snapshot is only written at
  // the end of that same cycle.
  always_comb begin
    w_initEntry = initEntry(r_initIdx, INTENSITY);
    w_word      = {N_DEV{w_initEntry}};
    if (r_initDone) begin
      if ((r_rowIdx == 3'd0) && w_txLoad) begin
        w_word = i_line1;
      end else begin
        w_word = r_frame[r_rowIdx];
      end
    end
  end

  // The driver always has a next word, so start is held high and words
  // follow each other back to back.
  max7219_word_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_wordTx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (1'b1),
    .i_word  (w_word),
    .o_load  (w_txLoad),
    .o_done  (w_txDone),
    .o_din   (o_max_din),
    .o_sclk  (o_max_clk),
    .o_cs_n  (o_max_cs_n)
  );

  // Sequencing happens only at word boundaries (transmitter done). A reinit
  // seen in the boundary cycle itself is honoured there; otherwise it is
  // parked in r_pending, so repeated pulses collapse into one restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_initIdx   <= 3'd0;
      r_rowIdx    <= 3'd0;
      r_pending   <= 1'b0;
      r_initDone  <= 1'b0;
      r_frameDone <= 1'b0;
      for (int k = 0; k < N_ROWS; k++) r_frame[k] <= 64'd0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_txDone) begin
        r_frameDone <= r_initDone && (r_rowIdx == LAST_ROW);
        if (r_pending || i_reinit) begin
          r_initIdx  <= 3'd0;
          r_rowIdx   <= 3'd0;
          r_pending  <= 1'b0;
          r_initDone <= 1'b0;
        end else if (!r_initDone) begin
          if (r_initIdx == LAST_INIT) begin
            r_initIdx  <= 3'd0;
            r_rowIdx   <= 3'd0;
            r_initDone <= 1'b1;
          end else begin
            r_initIdx <= r_initIdx + 3'd1;
          end
        end else if (r_rowIdx == LAST_ROW) begin
          r_rowIdx <= 3'd0;
        end else begin
          r_rowIdx <= r_rowIdx + 3'd1;
        end
      end else if (i_reinit) begin
        r_pending <= 1'b1;
      end

      // Whole-frame snapshot so later rows never mix two input frames
      if (w_txLoad && r_initDone && (r_rowIdx == 3'd0)) begin
        for (int k = 0; k < N_ROWS; k++) r_frame[k] <= w_lines[k];
      end
    end
  end

  assign o_init_done  = r_initDone;
  assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_max7219_chain_driver.sv
// -----------------------------------------------------------------------------
// tb_max7219_chain_driver
// Scoreboard bench: expected chain words are queued as stimulus is driven and
// compared when the chain latches a word (rising CS). A second instance with
// CLK_DIV=1 is used for the fastest-rate timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_max7219_chain_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst1_n;
  logic        reinit;
  logic        reinit1;
  logic [63:0] lines [8];

  logic        maxDin, maxClk, maxCsN, initDone, frameDone;
  logic        maxDin1, maxClk1, maxCsN1, initDone1, frameDone1;

  logic [63:0] expQ [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  logic [63:0] monShift = 64'd0;
  int          monBits  = 0;
  logic        prevSclk = 1'b0;
  logic        prevCs   = 1'b1;
  logic        prevFd   = 1'b0;
  int          lastFall = -1;
  int          frameDoneCnt = 0;

  localparam logic [63:0] CFG [5] = '{
    64'h0F000F000F000F00,
    64'h0B070B070B070B07,
    64'h0900090009000900,
    64'h0A080A080A080A08,
    64'h0C010C010C010C01
  };

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  max7219_chain_driver #(.CLK_DIV(2), .INTENSITY(4'h8), .N_ROWS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_line1(lines[0]), .i_line2(lines[1]), .i_line3(lines[2]), .i_line4(lines[3]),
    .i_line5(lines[4]), .i_line6(lines[5]), .i_line7(lines[6]), .i_line8(lines[7]),
    .i_reinit(reinit),
    .o_max_din(maxDin), .o_max_clk(maxClk), .o_max_cs_n(maxCsN),
    .o_init_done(initDone), .o_frame_done(frameDone)
  );

  max7219_chain_driver #(.CLK_DIV(1), .INTENSITY(4'h8), .N_ROWS(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst1_n),
    .i_line1(lines[0]), .i_line2(lines[1]), .i_line3(lines[2]), .i_line4(lines[3]),
    .i_line5(lines[4]), .i_line6(lines[5]), .i_line7(lines[6]), .i_line8(lines[7]),
    .i_reinit(reinit1),
    .o_max_din(maxDin1), .o_max_clk(maxClk1), .o_max_cs_n(maxCsN1),
    .o_init_done(initDone1), .o_frame_done(frameDone1)
  );

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Row frame k (0 = line1) carries digit register 8-k on every device
  function automatic logic [63:0] mkLine(input int k, input int seed);
    logic [63:0] v;
    v = 64'd0;
    for (int d = 0; d < 4; d++) begin
      v[d*16 +: 16] = {8'(8 - k), 8'(seed * 37 + k * 8 + d + 1)};
    end
    return v;
  endfunction

  task automatic applyStimulus(input int seed);
    for (int k = 0; k < 8; k++) lines[k] = mkLine(k, seed);
  endtask

  task automatic pushConfig(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(CFG[i]);
  endtask

  task automatic pushFrame(input int n);
    for (int k = 0; k < n; k++) expQ.push_back(lines[k]);
  endtask

  task automatic pulseReinit();
    @(negedge clk) reinit = 1'b1;
    @(negedge clk) reinit = 1'b0;
  endtask

  // Wait until at most n expected words remain; expired bound counts as a fail
  task automatic waitQueue(input int n, input string tag);
    int c;
    c = 0;
    while (expQ.size() > n && c < 20000) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 64'(expQ.size() <= n), 64'd1);
  endtask

  // Wait for the next falling CS (a word starts shifting)
  task automatic waitWordStart(input string tag);
    logic p;
    int   c;
    bit   seen;
    p = maxCsN;
    c = 0;
    seen = 0;
    while (!seen && c < 2000) begin
      @(negedge clk);
      if (p && !maxCsN) seen = 1;
      p = maxCsN;
      c++;
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  // Link monitor: collects bits on rising SCLK, checks word period between
  // CS falls and compares each latched word against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      monBits  = 0;
      prevSclk = 1'b0;
      prevCs   = 1'b1;
      prevFd   = 1'b0;
      lastFall = -1;
    end else begin
      if (maxClk && !prevSclk) begin
        monShift = {monShift[62:0], maxDin};
        monBits++;
      end
      if (!maxCsN && prevCs) begin
        if (lastFall >= 0) checkOutput("word_period", 64'(cyc - lastFall), 64'd263);
        lastFall = cyc;
        monBits  = 0;
      end
      if (maxCsN && !prevCs) begin
        checkOutput("word_bits", 64'(monBits), 64'd64);
        checkOutput("sb_pending", 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) checkOutput("sb_word", monShift, expQ.pop_front());
      end
      if (frameDone && prevFd) checkOutput("frame_done_width", 64'd2, 64'd1);
      if (frameDone && !prevFd) frameDoneCnt++;
      prevSclk = maxClk;
      prevCs   = maxCsN;
      prevFd   = frameDone;
    end
  end

  // CLK_DIV=1 instance: SCLK period 2 cycles, word period 132 cycles
  initial begin : fastRate
    int  t0;
    int  c;
    bit  seen;
    logic p;
    wait (rst1_n === 1'b1);
    for (int w = 0; w < 2; w++) begin
      p = maxCsN1; seen = 0; c = 0;
      while (!seen && c < 1000) begin
        @(negedge clk);
        if (p && !maxCsN1) seen = 1;
        p = maxCsN1;
        c++;
      end
      if (w == 0) t0 = cyc;
    end
    checkOutput("div1_word_period", 64'(cyc - t0), 64'd132);
    for (int w = 0; w < 2; w++) begin
      p = maxClk1; seen = 0; c = 0;
      while (!seen && c < 1000) begin
        @(negedge clk);
        if (!p && maxClk1) seen = 1;
        p = maxClk1;
        c++;
      end
      if (w == 0) t0 = cyc;
    end
    checkOutput("div1_sclk_period", 64'(cyc - t0), 64'd2);
  end

  initial begin : main
    int n;
    rst_n   = 1'b0;
    rst1_n  = 1'b0;
    reinit  = 1'b0;
    reinit1 = 1'b0;
    applyStimulus(0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_n", 64'(maxCsN), 64'd1);
    checkOutput("rst_clk", 64'(maxClk), 64'd0);
    checkOutput("rst_din", 64'(maxDin), 64'd0);
    checkOutput("rst_init_done", 64'(initDone), 64'd0);
    checkOutput("rst_frame_done", 64'(frameDone), 64'd0);

    // Config then two "0123" frames
    pushConfig(5);
    pushFrame(8);
    pushFrame(8);
    @(negedge clk);
    rst_n  = 1'b1;
    rst1_n = 1'b1;
    n = 0;
    while (maxCsN && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("first_shift_cycle", 64'(n), 64'd2);

    waitQueue(16, "wait_cfg_done");
    checkOutput("init_done_in_gap", 64'(initDone), 64'd0);
    waitWordStart("start_line1");
    checkOutput("init_done_rise", 64'(initDone), 64'd1);

    waitQueue(8, "wait_frame1");
    waitWordStart("start_frame2");
    checkOutput("frame_done_count1", 64'(frameDoneCnt), 64'd1);

    // Change line3 while frame 2 line2 is shifting
    waitQueue(7, "wait_f2_line1");
    waitWordStart("start_f2_line2");
    lines[2] = mkLine(2, 5);
    pushFrame(5);

    // Two reinit pulses in the middle of frame 3 line5
    waitQueue(1, "wait_f3_line4");
    waitWordStart("start_f3_line5");
    repeat (60) @(posedge clk);
    pulseReinit();
    checkOutput("init_done_hold", 64'(initDone), 64'd1);
    repeat (10) @(posedge clk);
    pulseReinit();
    pushConfig(5);
    pushFrame(8);
    waitQueue(13, "wait_f3_line5");
    waitWordStart("start_reinit_cfg");
    checkOutput("init_done_fall", 64'(initDone), 64'd0);
    waitQueue(8, "wait_cfg2_done");
    waitWordStart("start_f4_line1");
    checkOutput("init_done_rise2", 64'(initDone), 64'd1);
    checkOutput("frame_done_count2", 64'(frameDoneCnt), 64'd2);

    // Reset during bit 30 of frame 4 line3
    waitQueue(6, "wait_f4_line2");
    waitWordStart("start_f4_line3");
    repeat (120) @(posedge clk);
    #2;
    checkOutput("cs_low_before_rst", 64'(maxCsN), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cs_n", 64'(maxCsN), 64'd1);
    checkOutput("midrst_clk", 64'(maxClk), 64'd0);
    checkOutput("midrst_din", 64'(maxDin), 64'd0);
    checkOutput("midrst_init_done", 64'(initDone), 64'd0);
    expQ.delete();
    repeat (3) @(posedge clk);
    pushConfig(3);
    @(negedge clk);
    rst_n = 1'b1;

    // reinit during configuration word 3 restarts from word 1
    waitQueue(1, "wait_rcfg2");
    waitWordStart("start_rcfg3");
    pulseReinit();
    applyStimulus(3);
    pushConfig(5);
    pushFrame(8);
    waitQueue(0, "wait_final_frame");
    repeat (8) @(negedge clk);
    checkOutput("frame_done_total", 64'(frameDoneCnt), 64'd3);
    checkOutput("init_done_final", 64'(initDone), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
